// File: rtl/ref_level_est.sv
// ---------------------------------------------------------------------------
// ref_level_est
//   Windowed reference-level and average-power estimator for the M-ASK
//   receive path. Averages |dec_var| over N = 2**LOG2_N accepted symbols to
//   form the slicer reference level, then squares it and scales it by
//   REF_POWER in a two-stage registered multiply pipeline.
//
// Parameters
//   WIDTH      sample/result width, signed Q1.(WIDTH-1)
//   LOG2_N     log2 of window length (1..16)
//   REF_POWER  non-negative power scale constant, Q1.(WIDTH-1)
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset, clears all state
//   clk_en       in   symbol-rate enable (one sample per enabled cycle)
//   hold         in   freeze; while high clk_en is ignored
//   dec_var      in   signed decision variable
//   ref_level    out  mean |dec_var| of the last completed window (>= 0)
//   ref_valid    out  one-cycle pulse when ref_level updates
//   avg_power    out  trunc(trunc(ref_level^2) * REF_POWER) (>= 0)
//   power_valid  out  one-cycle pulse when avg_power updates
//   locked       out  high once the first window has completed
// ---------------------------------------------------------------------------
module ref_level_est #(
  parameter int                        WIDTH     = 18,
  parameter int                        LOG2_N    = 8,
  parameter logic signed [WIDTH-1:0]   REF_POWER = 18'sd65536
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     hold,
  input  logic signed [WIDTH-1:0]  dec_var,
  output logic signed [WIDTH-1:0]  ref_level,
  output logic                     ref_valid,
  output logic signed [WIDTH-1:0]  avg_power,
  output logic                     power_valid,
  output logic                     locked
);

  // Magnitudes never use the sign bit, so all internal datapaths are
  // WIDTH-1 bits unsigned.
  localparam int MAGW = WIDTH - 1;
  localparam int ACCW = MAGW + LOG2_N;
  localparam logic [MAGW-1:0] REF_MAG = REF_POWER[MAGW-1:0];

  logic              accept_s;
  logic [MAGW-1:0]   abs_s;
  logic [ACCW-1:0]   sum_s;
  logic              win_end_s;

  logic [ACCW-1:0]   acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [MAGW-1:0]   ref_q, ref_d;
  logic              ref_valid_q;
  logic              locked_q, locked_d;

  logic [2*MAGW-1:0] prod1_s, prod2_s;
  logic [MAGW-1:0]   sq_q, sq_d;
  logic              sq_valid_q;
  logic [MAGW-1:0]   pwr_q, pwr_d;
  logic              pwr_valid_q;

  assign accept_s = clk_en & ~hold;

  // Saturating absolute value: the most negative code maps to the largest
  // positive magnitude instead of wrapping back to itself.
  always_comb begin
    abs_s = dec_var[MAGW-1:0];
    if (dec_var[WIDTH-1]) begin
      if (dec_var[MAGW-1:0] == {MAGW{1'b0}}) begin
        abs_s = {MAGW{1'b1}};
      end else begin
        abs_s = ~dec_var[MAGW-1:0] + MAGW'(1);
      end
    end else begin
      abs_s = dec_var[MAGW-1:0];
    end
  end

  // The accumulator is sized for N full-scale magnitudes, so this add
  // cannot overflow.
  assign sum_s = acc_q + ACCW'(abs_s);

  // Window accumulation and end-of-window mean.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ref_d     = ref_q;
    locked_d  = locked_q;
    win_end_s = 1'b0;
    if (accept_s) begin
      if (cnt_q == {LOG2_N{1'b1}}) begin
        win_end_s = 1'b1;
        ref_d     = MAGW'(sum_s >> LOG2_N);
        acc_d     = {ACCW{1'b0}};
        cnt_d     = {LOG2_N{1'b0}};
        locked_d  = 1'b1;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + LOG2_N'(1);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Both multiplier operands are below 1.0, so the product fits in
  // 2*MAGW bits and the Q-format realignment is a plain right shift.
  assign prod1_s = {{MAGW{1'b0}}, ref_q} * {{MAGW{1'b0}}, ref_q};
  assign prod2_s = {{MAGW{1'b0}}, sq_q}  * {{MAGW{1'b0}}, REF_MAG};

  // Power pipeline: each stage loads only when its input is freshly valid.
  always_comb begin
    sq_d  = sq_q;
    pwr_d = pwr_q;
    if (ref_valid_q) begin
      sq_d = MAGW'(prod1_s >> MAGW);
    end else begin
      sq_d = sq_q;
    end
    if (sq_valid_q) begin
      pwr_d = MAGW'(prod2_s >> MAGW);
    end else begin
      pwr_d = pwr_q;
    end
  end

  // State registers; reset also flushes the power pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= {ACCW{1'b0}};
      cnt_q       <= {LOG2_N{1'b0}};
      ref_q       <= {MAGW{1'b0}};
      ref_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      sq_q        <= {MAGW{1'b0}};
      sq_valid_q  <= 1'b0;
      pwr_q       <= {MAGW{1'b0}};
      pwr_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ref_q       <= ref_d;
      ref_valid_q <= win_end_s;
      locked_q    <= locked_d;
      sq_q        <= sq_d;
      sq_valid_q  <= ref_valid_q;
      pwr_q       <= pwr_d;
      pwr_valid_q <= sq_valid_q;
    end
  end

  assign ref_level   = {1'b0, ref_q};
  assign ref_valid   = ref_valid_q;
  assign avg_power   = {1'b0, pwr_q};
  assign power_valid = pwr_valid_q;
  assign locked      = locked_q;

endmodule
